// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: fetches one 32-bit instruction at a time from a
// 64-bit-wide instruction memory and presents it to decode with a
// valid/ready handshake. Only one memory request is in flight at a time, and
// the fetch pc can be redirected by the execute stage.
// Optional macro YSYX_22050612_IFU_PERF_EN adds fetch/stall performance counters.
module ysyx_22050612_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [63:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
`ifdef YSYX_22050612_IFU_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;

  logic [63:0] redirect_target;
  logic        req_fire;
  logic        inst_fire;

  // Redirect targets are word aligned; the low two bits are discarded.
  assign redirect_target = redirect_pc & ~64'h3;

  // Request is masked while reset is held so nothing leaks onto the bus.
  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_req_addr  = {pc_q[63:3], 3'b000};
  assign inst_valid     = (state_q == S_OUT);
  assign inst           = inst_q;
  assign inst_pc        = pc_q;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign inst_fire = inst_valid && inst_ready;

  // Next-state logic for the fetch sequencer, pc, drop flag and captured word.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        if (req_fire) begin
          state_d = S_WAIT;
          // The request in flight is for the old pc; its data must be thrown away.
          if (redirect_valid) begin
            drop_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_target;
        end
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            inst_d  = pc_q[2] ? imem_rsp_data[63:32] : imem_rsp_data[31:0];
            state_d = S_OUT;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        // A redirect squashes the held instruction even if decode takes it.
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = S_REQ;
        end else if (inst_fire) begin
          pc_d    = pc_q + 64'd4;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

`ifdef YSYX_22050612_IFU_PERF_EN
  logic [63:0] perf_fetch_q, perf_fetch_d;
  logic [63:0] perf_stall_q, perf_stall_d;

  // Counters advance on every decode handshake and on every back-pressured cycle.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (inst_fire) begin
      perf_fetch_d = perf_fetch_q + 64'd1;
    end
    if (inst_valid && !inst_ready) begin
      perf_stall_d = perf_stall_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= 64'd0;
      perf_stall_q <= 64'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif

  // Fetch sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Bench for the fetch unit: a latency-programmable memory model, a per-cycle
// architectural model of the fetch stream, and directed scenarios with
// hand-computed literal expectations.
module tb_ysyx_22050612_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [63:0] imem_rsp_data = 64'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
`ifdef YSYX_22050612_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  bit stray    = 1'b0;

  ysyx_22050612_ifu #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef YSYX_22050612_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: a fixed word at the reset vector, address-derived elsewhere.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [31:0] lo32;
    lo32 = a[31:0];
    if (a == 64'h0000_0000_8000_0000) return 64'h0000_0013_0010_0093;
    return {(lo32 + 32'd4) ^ 32'h5500_0000, lo32 ^ 32'hAA00_0000};
  endfunction

  // The instruction at a byte address is the 32-bit slice of its doubleword.
  function automatic logic [31:0] inst_at(input logic [63:0] pc);
    logic [63:0] w;
    w = mem_word(pc & ~64'h7) >> (32 * int'(pc[2]));
    return w[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req_valid) return;
    end
    chk("wait_req_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_inst();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_valid) return;
    end
    chk("wait_inst_timeout", 64'd0, 64'd1);
  endtask

  // Memory: answers an accepted request mem_lat cycles later; can inject a stray pulse.
  initial begin
    bit          pend;
    int          cnt;
    logic [63:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = 64'h0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        pend  = 1'b1;
        cnt   = mem_lat;
        paddr = imem_req_addr;
      end
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 64'h0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend           = 1'b0;
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
        end
      end else if (stray) begin
        stray          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      end
    end
  end

  // Architectural model: the stream of delivered (pc, inst) pairs and request addresses.
  initial begin
    logic [63:0] m_pc;
    bit          outst;
    bit          iv_known;
    bit          iv_exp;
    logic [63:0] exp_fetch;
    logic [63:0] exp_stall;
    m_pc = RST_PC;
    outst = 1'b0;
    iv_known = 1'b0;
    iv_exp = 1'b0;
    exp_fetch = 64'd0;
    exp_stall = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_inst_pc", inst_pc, RST_PC);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        m_pc = RST_PC;
        outst = 1'b0;
        iv_known = 1'b0;
        exp_fetch = 64'd0;
        exp_stall = 64'd0;
      end else begin
        if (iv_known) chk("inst_valid_seq", {63'd0, inst_valid}, {63'd0, iv_exp});
        if (imem_req_valid) begin
          chk("one_outstanding", {63'd0, outst}, 64'd0);
          chk("req_addr", imem_req_addr, m_pc & ~64'h7);
          chk("req_and_inst", {63'd0, inst_valid}, 64'd0);
        end
        if (inst_valid) begin
          chk("inst_pc", inst_pc, m_pc);
          chk("inst", {32'd0, inst}, {32'd0, inst_at(m_pc)});
        end
`ifdef YSYX_22050612_IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, exp_fetch);
        chk("perf_stall", perf_stall_cnt, exp_stall);
`endif
        if (inst_valid && inst_ready) exp_fetch = exp_fetch + 64'd1;
        if (inst_valid && !inst_ready) exp_stall = exp_stall + 64'd1;
        if (imem_rsp_valid) outst = 1'b0;
        if (imem_req_valid && imem_req_ready) outst = 1'b1;
        iv_known = inst_valid;
        iv_exp   = inst_valid && !inst_ready && !redirect_valid;
        if (redirect_valid) m_pc = redirect_pc & ~64'h3;
        else if (inst_valid && inst_ready) m_pc = m_pc + 64'd4;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios.
  initial begin
    @(negedge clk);
    chk("lit_reset_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("lit_reset_inst_pc", inst_pc, 64'h8000_0000);
    repeat (2) @(negedge clk);

    // Reset release, first fetch with a one-cycle memory.
    tick();
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("lit_first_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("lit_first_req_addr", imem_req_addr, 64'h8000_0000);
    @(negedge clk);
    chk("lit_wait_no_inst", {63'd0, inst_valid}, 64'd0);
    @(negedge clk);
    chk("lit_first_inst_valid", {63'd0, inst_valid}, 64'd1);
    chk("lit_first_inst", {32'd0, inst}, 64'h0010_0093);
    chk("lit_first_inst_pc", inst_pc, 64'h8000_0000);

    // Decode back-pressure for five cycles.
    repeat (4) begin
      @(negedge clk);
      chk("lit_hold_inst", {32'd0, inst}, 64'h0010_0093);
      chk("lit_hold_pc", inst_pc, 64'h8000_0000);
    end
    tick();
    inst_ready = 1'b1;
`ifdef YSYX_22050612_IFU_PERF_EN
    @(negedge clk);
    chk("lit_stall_cnt5", perf_stall_cnt, 64'd5);
`endif

    // Sequential fetch with decode always ready.
    wait_req();
    chk("lit_second_req_addr", imem_req_addr, 64'h8000_0000);
    wait_inst();
    chk("lit_second_inst", {32'd0, inst}, 64'h0000_0013);
    chk("lit_second_inst_pc", inst_pc, 64'h8000_0004);
    wait_req();
    chk("lit_third_req_addr", imem_req_addr, 64'h8000_0008);
    wait_inst();
    chk("lit_third_inst", {32'd0, inst}, 64'h2A00_0008);

    // Redirect in S_WAIT with the response in the same cycle.
    wait_req();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    wait_req();
    chk("lit_redir_wait_addr", imem_req_addr, 64'h8000_0100);
    wait_inst();
    chk("lit_redir_wait_pc", inst_pc, 64'h8000_0100);
    chk("lit_redir_wait_inst", {32'd0, inst}, 64'h2A00_0100);

    // Redirect in S_WAIT with the response arriving later.
    mem_lat = 3;
    wait_req();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0010;
    tick();
    redirect_valid = 1'b0;
    mem_lat = 1;
    wait_req();
    chk("lit_redir_late_addr", imem_req_addr, 64'h8000_0010);
    wait_inst();
    chk("lit_redir_late_pc", inst_pc, 64'h8000_0010);

    // Redirect coincident with the decode handshake.
    wait_req();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0200;
    @(negedge clk);
    chk("lit_out_latency", {63'd0, inst_valid}, 64'd1);
    chk("lit_out_pc", inst_pc, 64'h8000_0014);
    tick();
    redirect_valid = 1'b0;
    wait_req();
    chk("lit_redir_out_addr", imem_req_addr, 64'h8000_0200);
    wait_inst();
    chk("lit_redir_out_inst", {32'd0, inst}, 64'h2A00_0200);

    // Redirect in S_REQ while the request is not accepted.
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0306;
    @(negedge clk);
    chk("lit_req_old_addr", imem_req_addr, 64'h8000_0200);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("lit_req_new_addr", imem_req_addr, 64'h8000_0300);
    tick();
    imem_req_ready = 1'b1;
    wait_inst();
    chk("lit_req_redir_pc", inst_pc, 64'h8000_0304);
    chk("lit_req_redir_inst", {32'd0, inst}, 64'hD500_0304);

    // Redirect in S_REQ coincident with the request handshake.
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0400;
    @(negedge clk);
    chk("lit_req_hs_valid", {63'd0, imem_req_valid}, 64'd1);
    tick();
    redirect_valid = 1'b0;
    wait_inst();
    chk("lit_req_hs_pc", inst_pc, 64'h8000_0400);
    chk("lit_req_hs_inst", {32'd0, inst}, 64'h2A00_0400);

    // pc wrap at the top of the address space.
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    wait_inst();
    chk("lit_top_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("lit_top_inst", {32'd0, inst}, 64'hAAFF_FFFC);
    mem_lat = 4;
    wait_req();
    chk("lit_wrap_addr", imem_req_addr, 64'h0);

    // Reset while waiting; the abandoned response arrives after release.
    tick();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("lit_midrst_inst", {32'd0, inst}, 64'h0);
    chk("lit_midrst_addr", imem_req_addr, 64'h8000_0000);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_release_req_valid", {63'd0, imem_req_valid}, 64'd1);
    tick();
    tick();
    @(negedge clk);
    chk("lit_stray_no_inst", {63'd0, inst_valid}, 64'd0);
    chk("lit_stray_req_valid", {63'd0, imem_req_valid}, 64'd1);
    tick();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    wait_inst();
    chk("lit_after_rst_pc", inst_pc, 64'h8000_0000);
    chk("lit_after_rst_inst", {32'd0, inst}, 64'h0010_0093);

    // Stray response while holding an instruction.
    stray = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("lit_stray_out_inst", {32'd0, inst}, 64'h0010_0093);
    end
    tick();
    inst_ready = 1'b1;
    wait_req();
    chk("lit_final_req_addr", imem_req_addr, 64'h8000_0000);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_ifu.md
YSYX_22050612_IFU -- requirements
Module: ysyx_22050612_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-006 SHALL have port imem_req_addr  output  64  fetch address, {pc[63:3],3'b000}.
REQ-007 SHALL have port imem_rsp_valid  input  1  response data valid, 1-cycle pulse.
REQ-008 SHALL have port imem_rsp_data  input  64  aligned doubleword.
REQ-009 SHALL have port inst_valid  output  1  instruction valid to decode.
REQ-010 SHALL have port inst_ready  input  1  decode accepts instruction.
REQ-011 SHALL have port inst  output  32  fetched instruction.
REQ-012 SHALL have port inst_pc  output  64  address of inst.
REQ-013 SHALL have port redirect_valid  input  1  execute stage supplies a taken dnpc.
REQ-014 SHALL have port redirect_pc  input  64  redirect target (execute-stage dnpc).

Function
REQ-015 SHALL implement states S_REQ, S_WAIT, S_OUT; at most one request outstanding.
REQ-016 S_REQ: imem_req_valid=1; on imem_req_valid&&imem_req_ready go S_WAIT.
REQ-017 S_WAIT: imem_req_valid=0; on imem_rsp_valid capture word, go S_OUT.
REQ-018 Word select: inst = pc[2] ? rsp_data[63:32] : rsp_data[31:0], sampled at capture.
REQ-019 S_OUT: inst_valid=1, inst/inst_pc stable; on inst_valid&&inst_ready pc<=pc+4, go S_REQ.
REQ-020 Minimum latency: request handshake cycle N, response N+1, inst_valid N+2; throughput <= 1 inst per 3 cycles.
REQ-021 imem_req_addr SHALL remain stable while imem_req_valid=1 and not accepted, except under REQ-022.
REQ-022 Redirect in S_REQ without handshake: pc<=redirect_pc, stay S_REQ.
REQ-023 Redirect in S_REQ with handshake same cycle: pc<=redirect_pc, set drop flag, go S_WAIT.
REQ-024 Redirect in S_WAIT: pc<=redirect_pc, set drop flag; response arriving (same cycle or later) SHALL be discarded, then go S_REQ, drop cleared.
REQ-025 Redirect in S_OUT: held instruction dropped (inst_valid 0 next cycle), pc<=redirect_pc, go S_REQ; redirect wins over a simultaneous inst handshake.
REQ-026 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into pc.
REQ-027 pc+4 SHALL wrap modulo 2^64.
REQ-028 imem_rsp_valid outside S_WAIT SHALL be ignored.
REQ-029 inst_valid SHALL be 0 in S_REQ and S_WAIT.

Reset
REQ-030 On rst_n=0 (async): state<=S_REQ, pc<=RESET_PC, drop<=0, captured inst<=32'h0.
REQ-031 Outputs during reset: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=RESET_PC, imem_req_addr=RESET_PC.
REQ-032 First request SHALL assert in the first cycle after rst_n deasserts; reset mid-transaction abandons it, late response ignored per REQ-028.

Configuration
REQ-033 Macro YSYX_22050612_IFU_PERF_EN: when defined, add outputs perf_fetch_cnt[63:0] (increments per inst handshake) and perf_stall_cnt[63:0] (increments each cycle inst_valid&&!inst_ready); both reset to 0, wrap modulo 2^64.
REQ-034 When YSYX_22050612_IFU_PERF_EN undefined, these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-035 Reset release, req_ready=1, rsp next cycle data 64'h0000_0013_0010_0093 -> req_addr 0x80000000, inst 0x00100093, inst_pc 0x80000000.
REQ-036 inst_ready=1 continuous, memory 1-cycle -> second req_addr 0x80000000, inst 0x00000013, inst_pc 0x80000004; third req_addr 0x80000008.
REQ-037 inst_ready=0 for 5 cycles in S_OUT -> inst/inst_pc stable; with PERF_EN perf_stall_cnt=5.
REQ-038 Redirect to 0x80000103 in S_WAIT, response arrives -> response discarded, next req_addr 0x80000100, inst_pc 0x80000100.
REQ-039 Redirect 0x80000200 coincident with inst handshake in S_OUT -> next req_addr 0x80000200; perf_fetch_cnt +1.
REQ-040 rst_n low in S_WAIT, stray rsp_valid after release -> ignored; first inst_pc 0x80000000.
